// File: rtl/rr_arbiter_4_if.sv
// Purpose: handshake bundle between the 4-queue round-robin arbiter and its FIFOs/mux.
// Latency: n/a (wires only).
// Backpressure: pause travels towards the arbiter; pop/select/valid/grant_idx travel away from it.
//
// slave  : arbiter side (consumes empty/pause, drives pop/select/valid/grant_idx)
// master : FIFO/mux side (drives empty/pause, observes the arbiter outputs)
interface rr_arbiter_4_if;
    logic [3:0] empty;      // per-FIFO empty flag, bit i = FIFO i
    logic       pause;      // downstream almost-full, 1 = no pop this cycle
    logic [3:0] pop;        // one-hot FIFO read strobe (combinational)
    logic [1:0] select;     // registered mux select of last popped word
    logic       valid;      // registered, mux output carries a popped word
    logic [1:0] grant_idx;  // registered current owner index

    modport slave (
        input  empty,
        input  pause,
        output pop,
        output select,
        output valid,
        output grant_idx
    );

    modport master (
        output empty,
        output pause,
        input  pop,
        input  select,
        input  valid,
        input  grant_idx
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Purpose: 4-queue round-robin pop arbiter with optional burst hold, driving a 4:1 word mux.
// Latency: pop is combinational; select/valid follow one cycle later, aligned with FIFO read data.
// Backpressure: pause=1 suppresses pop in the same cycle and freezes owner/burst state.
//
// Ports: clk (rising edge), reset (async, active-low), arb (rr_arbiter_4_if.slave:
//        empty/pause in, pop/select/valid/grant_idx out).
// Parameter BURST: max consecutive pops to one owner while another queue waits (1..15).
// Macro RR_BURST_EN: when defined, the owner keeps the grant for up to BURST pops;
//        when undefined, the grant rotates after every pop and the burst counter is absent.
module rr_arbiter_4 #(
    parameter int unsigned BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_4_if.slave arb
);

    typedef enum logic {IDLE, SERVE} mode_t;

    localparam logic [3:0] BURST_C = 4'(BURST);

    mode_t      mode_q, mode_d;
    logic [1:0] cur_q, cur_d;
    logic       valid_q;
    logic [1:0] select_q;

    logic [1:0] cand;        // first non-empty queue in search order cur+1..cur+4
    logic       cand_found;
    logic [1:0] probe;
    logic [3:0] pop_raw;
    logic [1:0] pop_idx;

`ifdef RR_BURST_EN
    logic [3:0] cnt_q, cnt_d;
`else
    logic unused_burst;
    assign unused_burst = ^BURST_C;
`endif

    // Rotating priority search; the fourth probe wraps back onto cur itself,
    // which gives the work-conserving case when only the owner has data.
    always_comb begin
        cand       = cur_q;
        cand_found = 1'b0;
        probe      = cur_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            probe = cur_q + 2'(k);
            if (!cand_found && !arb.empty[probe]) begin
                cand       = probe;
                cand_found = 1'b1;
            end
        end
    end

    always_comb begin
        pop_raw = 4'b0000;
        pop_idx = cur_q;
        mode_d  = mode_q;
        cur_d   = cur_q;
`ifdef RR_BURST_EN
        cnt_d   = cnt_q;
`endif
        if (!arb.pause) begin
            if (!cand_found) begin
                mode_d = IDLE;
`ifdef RR_BURST_EN
            end else if (mode_q == SERVE && !arb.empty[cur_q] && cnt_q < BURST_C) begin
                // Owner still within its burst allowance.
                pop_raw[cur_q] = 1'b1;
                pop_idx        = cur_q;
                cnt_d          = cnt_q + 4'd1;
`endif
            end else begin
                pop_raw[cand] = 1'b1;
                pop_idx       = cand;
                cur_d         = cand;
                mode_d        = SERVE;
`ifdef RR_BURST_EN
                if (cand != cur_q) begin
                    cnt_d = 4'd1;
                end else if (cnt_q < BURST_C) begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= IDLE;
            cur_q    <= 2'd3;
            valid_q  <= 1'b0;
            select_q <= 2'd0;
        end else begin
            mode_q  <= mode_d;
            cur_q   <= cur_d;
            valid_q <= |pop_raw;
            if (|pop_raw) begin
                select_q <= pop_idx;
            end
        end
    end

`ifdef RR_BURST_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Reset gates the Mealy pop so no strobe reaches the FIFOs while they are held in reset.
    assign arb.pop       = pop_raw & {4{reset}};
    assign arb.valid     = valid_q;
    assign arb.select    = select_q;
    // cur_q is loaded with cur_next every edge, so it is the registered grant index.
    assign arb.grant_idx = cur_q;

endmodule
